mips32_shift_iter: RTL and testbench
====================================

# mips32_shift_iter

Multi-cycle, iterative shift unit for the MIPS32 datapath: shifts one bit position per clock under a valid/ready handshake on both its input and its output. It covers the complementary direction set to the single-cycle barrel shifter, with rotate-left as the rotate operation. It sits beside the ALU as a low-area shift path for slow or multi-cycle execution stages. Results are bit-exact with a 32-bit MIPS shift of the same operand, amount and operation.

## Interface

Parameters:

- WIDTH, 32, operand/result width in bits.
- AMT_W, 5, shift-amount width. Must equal log2(WIDTH).

Ports:

- clk  input  1  clock. All state changes on the rising edge.
- rst  input  1  reset. Asynchronous and active-high.
- flush  input  1  synchronous abort. Discards the operation in flight.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request. High only in IDLE.
- shift_in  input  WIDTH  operand.
- shift_amount  input  AMT_W  shift distance, 0..WIDTH-1.
- shift_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROTL.
- out_valid  output  1  result valid. High only in DONE.
- out_ready  input  1  consumer takes the result.
- shift_out  output  WIDTH  result register.
- busy  output  1  high in SHIFT or DONE.

## Operation

- States:
  - IDLE: in_ready=1.
  - SHIFT: iterating.
  - DONE: out_valid=1, shift_out stable.
- Registers: data (WIDTH), count (AMT_W), op (2), sign (1).
- Accept occurs on an edge where in_valid && in_ready.
  - On accept, load data=shift_in, count=shift_amount, op=shift_op, sign=shift_in[WIDTH-1].
  - Next state is DONE if shift_amount==0, otherwise SHIFT.
- Each edge in SHIFT updates data by one position and decrements count.
  - SLL: data = {data[WIDTH-2:0], 0}.
  - SRL: data = {0, data[WIDTH-1:1]}.
  - SRA: data = {sign, data[WIDTH-1:1]}. The sign is captured at accept, not re-read from data.
  - ROTL: data = {data[WIDTH-2:0], data[WIDTH-1]}.
  - When count==1 on that edge, next state is DONE.
- shift_out is driven from data. It is only meaningful while out_valid=1.
- DONE holds, with shift_out frozen, until out_valid && out_ready. On that edge the state returns to IDLE.
- No new accept can occur on the same edge as a result handoff, because in_ready=0 in DONE.
- flush=1 on any edge forces IDLE. It takes priority over accept, shift and handoff.
  - A result pending in DONE is lost.
  - data/count are not cleared.
- shift_op and shift_amount are ignored outside the accept edge. Changing the inputs mid-operation has no effect.

## Timing

- Reset (asynchronous, immediate): state=IDLE, data=0, count=0, op=0, sign=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, shift_out=0.
  - Requests presented while rst=1 are ignored, since no flop updates.
- Reset mid-operation aborts immediately. No partial result is ever presented.
- Latency: with accept at edge E0 and amount n, out_valid rises after edge En (after E0 itself for n=0).
- Occupancy: n+1 cycles from accept to the first cycle out_valid can be consumed. Minimum request period is n+2 cycles with out_ready held at 1.
- in_ready, out_valid and busy are decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- shift_amount=WIDTH-1 is the longest case: 31 shift edges.

## Test plan

- Reset: assert rst mid-SHIFT (SLL by 20) -> outputs immediately in_ready=1, out_valid=0, busy=0, shift_out=0. After release, the next request completes normally.
- SLL/SRL: 0x8000_0001 SLL 4 -> 0x0000_0010. 0x8000_0001 SRL 31 -> 0x0000_0001. In both cases out_valid rises exactly n edges after accept, and in_ready stays 0 throughout.
- SRA/ROTL: 0x8000_00F0 SRA 4 -> 0xF800_000F. 0x8000_00F0 ROTL 4 -> 0x0000_0F08. 0x7FFF_FFFF SRA 31 -> 0x0000_0000.
- Amount zero: 0x1234_5678 with each of the four ops and amount 0 -> 0x1234_5678, out_valid high after the accept edge.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and shift_in -> shift_out stays constant and there is no second accept. Raising out_ready returns the unit to IDLE on that edge.
- Flush: flush during SHIFT (ROTL by 16) -> IDLE next edge with no out_valid. Flush in DONE drops the result. Flush coincident with an accept -> no accept, state stays IDLE.

Source files
------------

// File: rtl/mips32_shift_iter.sv
// rtl/mips32_shift_iter.sv - iterative one-bit-per-clock shifter (SLL/SRL/SRA/ROTL) with valid/ready handshakes
module mips32_shift_iter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] shift_in,
    input  logic [AMT_W-1:0] shift_amount,
    input  logic [1:0]       shift_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] shift_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTL = 2'b11;

    state_t             state;
    logic [WIDTH-1:0]   data;
    logic [AMT_W-1:0]   count;
    logic [1:0]         op;
    logic               sign;
    logic [WIDTH-1:0]   data_step;

    // SRA fills from the sign captured at accept, not from the evolving data MSB
    always_comb begin
        data_step = data;
        case (op)
            OP_SLL:  data_step = {data[WIDTH-2:0], 1'b0};
            OP_SRL:  data_step = {1'b0, data[WIDTH-1:1]};
            OP_SRA:  data_step = {sign, data[WIDTH-1:1]};
            OP_ROTL: data_step = {data[WIDTH-2:0], data[WIDTH-1]};
            default: data_step = data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            data  <= '0;
            count <= '0;
            op    <= 2'b00;
            sign  <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        data  <= shift_in;
                        count <= shift_amount;
                        op    <= shift_op;
                        sign  <= shift_in[WIDTH-1];
                        state <= (shift_amount == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    data  <= data_step;
                    count <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_SHIFT) || (state == S_DONE);
    assign shift_out = data;

endmodule

// File: tb/tb_mips32_shift_iter.sv
// tb/tb_mips32_shift_iter.sv - randomized and directed self-checking bench for mips32_shift_iter
module tb_mips32_shift_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] shift_in;
    logic [4:0]  shift_amount;
    logic [1:0]  shift_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] shift_out;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    mips32_shift_iter #(.WIDTH(32), .AMT_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .shift_in(shift_in), .shift_amount(shift_amount), .shift_op(shift_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .shift_out(shift_out), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(logic [31:0] x, int n, int o);
        case (o)
            0:       return x << n;
            1:       return x >> n;
            2:       return 32'($signed(x) >>> n);
            default: return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
        endcase
    endfunction

    // Issues one request from IDLE, waits for the result, then hands it off.
    task automatic do_req(input logic [31:0] x, input logic [4:0] n, input logic [1:0] o,
                          output logic [31:0] res, output int lat, output bit ir_bad);
        @(negedge clk);
        shift_in = x; shift_amount = n; shift_op = o; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        shift_in = $urandom; shift_amount = 5'($urandom); shift_op = 2'($urandom);
        lat = 0; ir_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ir_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (in_ready) ir_bad = 1'b1;
        res = shift_out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r; int lat; bit irb;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || shift_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_init: in_ready=%b out_valid=%b busy=%b shift_out=%h, want 1 0 0 00000000",
                     in_ready, out_valid, busy, shift_out);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        shift_in = 32'hDEAD_BEEF; shift_amount = 5'd20; shift_op = 2'b00; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || shift_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_shift: in_ready=%b out_valid=%b busy=%b shift_out=%h, want 1 0 0 00000000",
                     in_ready, out_valid, busy, shift_out);
        end
        @(negedge clk); rst = 1'b0;
        do_req(32'h0000_0F0F, 5'd7, 2'b01, r, lat, irb);
        n_tests++;
        if (r !== ref_shift(32'h0000_0F0F, 7, 1) || lat !== 7) begin
            n_fail++;
            $display("FAIL reset_recover: result=%h lat=%0d, want %h lat=7", r, lat, ref_shift(32'h0000_0F0F, 7, 1));
        end
    endtask

    task automatic test_directed();
        logic [31:0] xs [5] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_00F0, 32'h8000_00F0, 32'h7FFF_FFFF};
        int          ns [5] = '{4, 31, 4, 4, 31};
        int          os [5] = '{0, 1, 2, 3, 2};
        logic [31:0] ex [5] = '{32'h0000_0010, 32'h0000_0001, 32'hF800_000F, 32'h0000_0F08, 32'h0000_0000};
        logic [31:0] r; int lat; bit irb;
        for (int i = 0; i < 5; i++) begin
            do_req(xs[i], 5'(ns[i]), 2'(os[i]), r, lat, irb);
            n_tests++;
            if (r !== ex[i] || lat !== ns[i] || irb) begin
                n_fail++;
                $display("FAIL directed_%0d: result=%h lat=%0d in_ready_seen=%b, want %h lat=%0d in_ready_seen=0",
                         i, r, lat, irb, ex[i], ns[i]);
            end
        end
    endtask

    task automatic test_amount_zero();
        logic [31:0] r; int lat; bit irb;
        for (int o = 0; o < 4; o++) begin
            do_req(32'h1234_5678, 5'd0, 2'(o), r, lat, irb);
            n_tests++;
            if (r !== 32'h1234_5678 || lat !== 0) begin
                n_fail++;
                $display("FAIL amount_zero_op%0d: result=%h lat=%0d, want 12345678 lat=0", o, r, lat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, r; int n, o, lat; bit irb;
        for (int i = 0; i < 30; i++) begin
            x = $urandom; n = $urandom_range(0, 31); o = $urandom_range(0, 3);
            if (i == 0) n = 31;
            do_req(x, 5'(n), 2'(o), r, lat, irb);
            n_tests++;
            if (r !== ref_shift(x, n, o) || lat !== n || irb) begin
                n_fail++;
                $display("FAIL random_%0d op=%0d n=%0d x=%h: result=%h lat=%0d irb=%b, want %h lat=%0d irb=0",
                         i, o, n, x, r, lat, irb, ref_shift(x, n, o), n);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] x, held; int w;
        x = $urandom;
        @(negedge clk);
        shift_in = x; shift_amount = 5'd3; shift_op = 2'b10; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        held = shift_out;
        n_tests++;
        if (held !== ref_shift(x, 3, 2) || w !== 3) begin
            n_fail++;
            $display("FAIL bp_result: result=%h wait=%0d, want %h wait=3", held, w, ref_shift(x, 3, 2));
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom); shift_in = $urandom; shift_amount = 5'($urandom);
            @(negedge clk);
            n_tests++;
            if (shift_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: shift_out=%h out_valid=%b in_ready=%b, want %h 1 0",
                         i, shift_out, out_valid, in_ready, held);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_second_accept: busy=%b out_valid=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat, w; bit irb, saw;
        @(negedge clk);
        shift_in = 32'hA5A5_0001; shift_amount = 5'd16; shift_op = 2'b11; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_shift: in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) saw = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (saw) begin
            n_fail++;
            $display("FAIL flush_shift_no_result: out_valid_seen=%b, want 0", saw);
        end
        shift_in = 32'h0000_0003; shift_amount = 5'd2; shift_op = 2'b00; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        n_tests++;
        if (w !== 2 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_done: wait=%0d out_valid=%b in_ready=%b, want 2 0 1", w, out_valid, in_ready);
        end
        shift_in = 32'h1111_1111; shift_amount = 5'd0; shift_op = 2'b00; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk); in_valid = 1'b0; flush = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_accept: in_ready=%b busy=%b out_valid=%b, want 1 0 0", in_ready, busy, out_valid);
        end
        do_req(32'hC000_0000, 5'd5, 2'b10, r, lat, irb);
        n_tests++;
        if (r !== 32'hFE00_0000 || lat !== 5) begin
            n_fail++;
            $display("FAIL flush_recover: result=%h lat=%0d, want fe000000 lat=5", r, lat);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        shift_in = '0; shift_amount = '0; shift_op = '0;
        #3;
        test_reset();
        test_directed();
        test_amount_zero();
        test_random();
        test_backpressure();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
